// File: rtl/shift_sequencer8.sv
// Multi-cycle shift/rotate engine: loads an operand on start, then applies one
// single-bit shift per clock for shamt cycles and pulses done when finished.
module shift_sequencer8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;

  logic [WIDTH-1:0] lsl_val, lsr_val, shift_val;

  // Plain one-bit left/right moves; the other operations reuse these and only
  // differ in the bit shifted in.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign lsl_val[gi+1] = q_reg[gi];
      assign lsr_val[gi]   = q_reg[gi+1];
    end
  endgenerate
  assign lsl_val[0]       = 1'b0;
  assign lsr_val[WIDTH-1] = 1'b0;

  always_comb begin
    shift_val = q_reg;
    case (op_reg)
      OP_LSL:  shift_val = lsl_val;
      OP_LSR:  shift_val = lsr_val;
      OP_ASR:  shift_val = {q_reg[WIDTH-1], lsr_val[WIDTH-2:0]};
      OP_ROL:  shift_val = {lsl_val[WIDTH-1:1], q_reg[WIDTH-1]};
      OP_ROR:  shift_val = {q_reg[0], lsr_val[WIDTH-2:0]};
      default: shift_val = q_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          q_next     = d_in;
          op_next    = op;
          cnt_next   = shamt;
          state_next = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // cnt is never zero here, so the decrement cannot wrap.
        q_next   = shift_val;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      cnt_reg   <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
    end
  end

  assign q    = q_reg;
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_shift_sequencer8.sv
// Scoreboard bench for shift_sequencer8: stimulus queues the expected q trace and
// final result, a negedge monitor pops and compares while the DUT is busy/done.
module tb_shift_sequencer8;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [2:0] shamt;
  logic [7:0] d_in;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] final_q;
    int         busy_len;
    string      name;
  } result_t;

  logic [7:0] trace_q[$];
  result_t    done_q[$];
  logic       mon_en = 1'b0;
  int         busy_len = 0;

  shift_sequencer8 #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .shamt(shamt),
    .d_in(d_in), .q(q), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] f1(input logic [2:0] o, input logic [7:0] v);
    case (o)
      3'b000:  return {v[6:0], 1'b0};
      3'b001:  return {1'b0, v[7:1]};
      3'b010:  return {v[7], v[7:1]};
      3'b011:  return {v[6:0], v[7]};
      3'b100:  return {v[0], v[7:1]};
      default: return v;
    endcase
  endfunction

  // Expected q in each busy cycle: the operand, then one more shift per cycle.
  task automatic expect_txn(input string name, input logic [2:0] o, input logic [2:0] n,
                            input logic [7:0] din, input logic [7:0] final_q);
    logic [7:0] v;
    result_t r;
    v = din;
    trace_q.push_back(v);
    for (int i = 0; i < int'(n); i++) begin
      v = f1(o, v);
      trace_q.push_back(v);
    end
    r.final_q  = final_q;
    r.busy_len = int'(n) + 1;
    r.name     = name;
    done_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (busy) begin
        busy_len++;
        if (trace_q.size() == 0) check("unexpected_busy", 1, 0);
        else check("trace_q", int'(q), int'(trace_q.pop_front()));
      end
      if (done) begin
        result_t r;
        check("done_implies_busy", int'(busy), 1);
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          r = done_q.pop_front();
          check({r.name, "_done_q"}, int'(q), int'(r.final_q));
          check({r.name, "_busy_len"}, busy_len, r.busy_len);
          $display("txn %s: q=%02h busy_len=%0d", r.name, q, busy_len);
        end
      end
      if (!busy) busy_len = 0;
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [2:0] n,
                     input logic [7:0] din, input logic [7:0] final_q);
    @(negedge clk);
    expect_txn(name, o, n, din, final_q);
    start = 1'b1; op = o; shamt = n; d_in = din;
    @(negedge clk);
    start = 1'b0; d_in = ~din; op = 3'b000; shamt = 3'd7;
    wait_done(name);
    @(negedge clk);
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_idle_hold"}, int'(q), int'(final_q));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'b000; shamt = 3'd0; d_in = 8'h00;
    #2;
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a shift sequence.
    @(negedge clk);
    start = 1'b1; op = 3'b000; shamt = 3'd5; d_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_q", int'(q), 8'hFC);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_q", int'(q), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(done), 0);
    $display("txn async_reset: q=%02h busy=%0d done=%0d", q, busy, done);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_q", int'(q), 0);
    check("post_reset_busy", int'(busy), 0);

    mon_en = 1'b1;
    run("lsl",  3'b000, 3'd3, 8'hB3, 8'h98);
    run("asr",  3'b010, 3'd2, 8'h90, 8'hE4);
    run("ror",  3'b100, 3'd7, 8'h81, 8'h03);
    run("rol",  3'b011, 3'd1, 8'h80, 8'h01);
    run("lsr",  3'b001, 3'd1, 8'h01, 8'h00);
    run("zero", 3'b001, 3'd0, 8'h5A, 8'h5A);
    run("rsvd", 3'b110, 3'd4, 8'h3C, 8'h3C);

    // start held high: second request only taken in the first idle cycle.
    @(negedge clk);
    expect_txn("b2b_first",  3'b011, 3'd2, 8'h11, 8'h44);
    expect_txn("b2b_second", 3'b011, 3'd2, 8'h05, 8'h14);
    start = 1'b1; op = 3'b011; shamt = 3'd2; d_in = 8'h11;
    @(negedge clk);
    d_in = 8'h05;
    wait_done("b2b_first");
    @(negedge clk);
    check("b2b_gap_busy", int'(busy), 0);
    @(negedge clk);
    check("b2b_second_accepted", int'(busy), 1);
    start = 1'b0; d_in = 8'hAA;
    wait_done("b2b_second");
    @(negedge clk);
    check("b2b_idle_hold", int'(q), 8'h14);

    repeat (2) @(negedge clk);
    check("trace_queue_empty", trace_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
